// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: drives a multi-cycle req/ack data-memory port, stalls the front end
// while an access is pending, resolves the branch and owns the M->W register. Optional MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instrM,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic          MemWriteM,
    input  logic          BranchM,
    input  logic          ZeroM,
    input  logic [DW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    input  logic [RW-1:0] WriteRegM,
    output logic          PCSrcM,
    output logic          stallM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [31:0]   instrW,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic [DW-1:0] ReadDataW,
    output logic [DW-1:0] ALUOutW,
    output logic [RW-1:0] WriteRegW,
    output logic          mem_err
);

    // state | meaning
    // IDLE  | no access pending; non-memory ops pass to W in one cycle
    // REQ   | dmem_req held, waiting for dmem_ack (or timeout)
    // DONE  | access finished; load data / store result written to W
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state, state_next;
    logic          accM;
    logic          req_start, req_end, w_pass, w_kill, rd_sel;
    logic          tmo_hit, tmo_fire, tmo_flag;
    logic [DW-1:0] rbuf;

    assign accM   = MemtoRegM | MemWriteM;
    assign PCSrcM = BranchM & ZeroM;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stallM     = 1'b0;
        req_start  = 1'b0;
        req_end    = 1'b0;
        tmo_fire   = 1'b0;
        w_pass     = 1'b0;
        w_kill     = 1'b0;
        rd_sel     = 1'b0;
        case (state)
            IDLE: begin
                if (accM) begin
                    stallM     = 1'b1;
                    req_start  = 1'b1;
                    state_next = REQ;
                end else begin
                    w_pass = 1'b1;
                end
            end
            REQ: begin
                stallM = 1'b1;
                // a completing ack wins over a timeout in the same cycle
                if (dmem_ack) begin
                    req_end    = 1'b1;
                    state_next = DONE;
                end else if (tmo_hit) begin
                    req_end    = 1'b1;
                    tmo_fire   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                w_pass     = 1'b1;
                rd_sel     = 1'b1;
                w_kill     = tmo_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rbuf       <= '0;
            instrW     <= '0;
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            ReadDataW  <= '0;
            ALUOutW    <= '0;
            WriteRegW  <= '0;
        end else begin
            if (req_start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteM;
                dmem_addr  <= ALUOutM;
                dmem_wdata <= WriteDataM;
            end else if (req_end) begin
                dmem_req <= 1'b0;
            end
            // stores and aborted loads leave zero in the read buffer
            if (req_end) rbuf <= (!tmo_fire && !dmem_we) ? dmem_rdata : '0;
            if (w_pass) begin
                instrW    <= instrM;
                RegWriteW <= RegWriteM & ~w_kill;
                MemtoRegW <= MemtoRegM;
                ReadDataW <= rd_sel ? rbuf : '0;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
            end else begin
                instrW    <= '0;
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                ReadDataW <= '0;
                ALUOutW   <= '0;
                WriteRegW <= '0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;

    // hit on the REQ cycle in which the ackless count would reach TIMEOUT
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            if (req_start) begin
                tmo_cnt  <= '0;
                tmo_flag <= 1'b0;
            end else if (state == REQ && !dmem_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_fire) begin
                tmo_flag <= 1'b1;
                mem_err  <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
    assign mem_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of single-cycle ops plus hand-written
// access, reset-abort and timeout sequences.
module tb_mem_stage_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instrM;
    logic          RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
    logic [DW-1:0] ALUOutM, WriteDataM;
    logic [RW-1:0] WriteRegM;
    logic          PCSrcM, stallM, dmem_req, dmem_we, dmem_ack, mem_err;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0]   instrW;
    logic          RegWriteW, MemtoRegW;
    logic [DW-1:0] ReadDataW, ALUOutW;
    logic [RW-1:0] WriteRegW;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instrM(instrM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchM(BranchM), .ZeroM(ZeroM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM), .PCSrcM(PCSrcM), .stallM(stallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .instrW(instrW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   instr;
        logic          regwrite, branch, zero;
        logic [DW-1:0] alu;
        logic [RW-1:0] wreg;
        logic          exp_pcsrc;
        logic          exp_regw;
        logic [DW-1:0] exp_alu;
        logic [RW-1:0] exp_wreg;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        instrM = '0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        BranchM = 0; ZeroM = 0; ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    endtask

    // Drives one load/store; ack given on REQ cycle ack_at (0 = never within budget).
    // Returns stalled-cycle count and REQ-cycle count; ends one edge after DONE.
    task automatic run_access(input string tag, input logic is_store, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                              input int budget, output int stalls, output int reqs);
        logic done;
        instrM = is_store ? 32'hAC00_0000 : 32'h8C00_0000;
        RegWriteM = ~is_store; MemtoRegM = ~is_store; MemWriteM = is_store;
        ALUOutM = addr; WriteDataM = wd; WriteRegM = 5'd8;
        stalls = 0; reqs = 0; done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            #1;
            if (stallM) stalls++;
            if (dmem_req) begin
                reqs++;
                chk({tag, "_addr"}, dmem_addr, addr);
                chk({tag, "_wdata"}, dmem_wdata, wd);
                chk({tag, "_we"}, dmem_we, is_store);
                if (reqs == ack_at) begin
                    dmem_ack = 1; dmem_rdata = rd;
                end
            end else if (reqs > 0 && !stallM) begin
                done = 1;
            end
            tick();
            dmem_ack = 0; dmem_rdata = 32'h5A5A_5A5A;
        end
        if (ack_at > 0) chk({tag, "_finished"}, done, 1'b1);
    endtask

    initial begin
        int stalls, reqs;
        vecs[0] = '{32'h00A6_2820, 1, 0, 0, 32'h0000_0010, 5'd5,  0, 1, 32'h0000_0010, 5'd5};
        vecs[1] = '{32'h1085_0004, 0, 1, 1, 32'h0000_0000, 5'd0,  1, 0, 32'h0000_0000, 5'd0};
        vecs[2] = '{32'h1085_0008, 0, 1, 0, 32'h0000_0004, 5'd0,  0, 0, 32'h0000_0004, 5'd0};
        vecs[3] = '{32'h0085_1822, 1, 0, 1, 32'h0000_0000, 5'd3,  0, 1, 32'h0000_0000, 5'd3};
        vecs[4] = '{32'h0000_F827, 1, 0, 0, 32'hFFFF_FFFF, 5'd31, 0, 1, 32'hFFFF_FFFF, 5'd31};

        set_nop();
        reset = 0; dmem_ack = 0; dmem_rdata = '0;
        tick(); tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_instrW", instrW, 0);
        chk("rst_regw", RegWriteW, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", stallM, 0);
        reset = 1;
        tick();

        for (int i = 0; i < 5; i++) begin
            instrM = vecs[i].instr; RegWriteM = vecs[i].regwrite;
            BranchM = vecs[i].branch; ZeroM = vecs[i].zero;
            ALUOutM = vecs[i].alu; WriteRegM = vecs[i].wreg;
            #1;
            chk($sformatf("v%0d_pcsrc", i), PCSrcM, vecs[i].exp_pcsrc);
            chk($sformatf("v%0d_stall", i), stallM, 0);
            chk($sformatf("v%0d_req", i), dmem_req, 0);
            tick();
            chk($sformatf("v%0d_regw", i), RegWriteW, vecs[i].exp_regw);
            chk($sformatf("v%0d_alu", i), ALUOutW, vecs[i].exp_alu);
            chk($sformatf("v%0d_wreg", i), WriteRegW, vecs[i].exp_wreg);
            chk($sformatf("v%0d_instr", i), instrW, vecs[i].instr);
            chk($sformatf("v%0d_rdata", i), ReadDataW, 0);
        end

        // load, ack on 2nd REQ cycle
        run_access("lw", 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 20, stalls, reqs);
        chk("lw_stalls", stalls, 3);
        chk("lw_rdata", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_memtoreg", MemtoRegW, 1);
        chk("lw_regw", RegWriteW, 1);
        chk("lw_wreg", WriteRegW, 8);
        set_nop();

        // fastest load: ack on first REQ cycle
        run_access("lw1", 0, 32'h104, 32'h0, 32'h0BAD_F00D, 1, 20, stalls, reqs);
        chk("lw1_stalls", stalls, 2);
        chk("lw1_rdata", ReadDataW, 32'h0BAD_F00D);
        set_nop();

        // store, ack on 3rd REQ cycle; rdata on ack must not leak to W
        run_access("sw", 1, 32'h200, 32'h1234, 32'hFFFF_FFFF, 3, 20, stalls, reqs);
        chk("sw_stalls", stalls, 4);
        chk("sw_regw", RegWriteW, 0);
        chk("sw_rdata", ReadDataW, 0);
        chk("sw_alu", ALUOutW, 32'h200);
        set_nop();

        // stray ack in IDLE
        dmem_ack = 1; dmem_rdata = 32'hCAFE_0000;
        #1;
        chk("stray_stall", stallM, 0);
        tick();
        dmem_ack = 0;
        chk("stray_req", dmem_req, 0);
        chk("stray_rdata", ReadDataW, 0);

        // reset while in REQ
        instrM = 32'h8C00_0000; RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h300; WriteRegM = 5'd9;
        tick();
        chk("rreq_req", dmem_req, 1);
        set_nop();
        reset = 0;
        tick();
        chk("rreq_req_drop", dmem_req, 0);
        chk("rreq_W", {instrW[15:0], 8'(ReadDataW), 3'(WriteRegW), RegWriteW, MemtoRegW, 3'(ALUOutW)}, 0);
        chk("rreq_stall", stallM, 0);
        reset = 1;
        dmem_ack = 1; dmem_rdata = 32'h7777_7777;
        tick();
        dmem_ack = 0;
        chk("rreq_stray_req", dmem_req, 0);
        chk("rreq_stray_rd", ReadDataW, 0);
        RegWriteM = 1; ALUOutM = 32'h44; WriteRegM = 5'd4;
        tick();
        chk("rreq_idle_alu", ALUOutW, 32'h44);
        set_nop();

`ifdef MEM_TIMEOUT_EN
        // ack on the 4th REQ cycle beats the timeout
        run_access("tack", 0, 32'h400, 32'h0, 32'h1357_9BDF, 4, 20, stalls, reqs);
        chk("tack_rdata", ReadDataW, 32'h1357_9BDF);
        chk("tack_regw", RegWriteW, 1);
        chk("tack_err", mem_err, 0);
        set_nop();
        run_access("tmo", 0, 32'h500, 32'h0, 32'h0, 0, 20, stalls, reqs);
        chk("tmo_reqs", reqs, 4);
        chk("tmo_err", mem_err, 1);
        chk("tmo_regw", RegWriteW, 0);
        chk("tmo_rdata", ReadDataW, 0);
        set_nop();
        RegWriteM = 1; ALUOutM = 32'h88; WriteRegM = 5'd2;
        tick();
        chk("tmo_sticky", mem_err, 1);
        chk("tmo_next_regw", RegWriteW, 1);
        set_nop();
`else
        run_access("hang", 0, 32'h500, 32'h0, 32'h0, 0, 12, stalls, reqs);
        chk("hang_stalls", stalls, 12);
        chk("hang_req", dmem_req, 1);
        chk("hang_err", mem_err, 0);
        set_nop();
        reset = 0;
        tick();
        reset = 1;
        chk("hang_reset_req", dmem_req, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
